// File: rtl/mult_arbiter.sv
// Round-robin arbiter/sequencer sharing one 4x16 multiplier among NREQ requesters.
// Optional WAIT watchdog is compiled in when MULT_ARB_TIMEOUT_EN is defined.
module mult_arbiter #(
    parameter int NREQ           = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NREQ-1:0]      i_req_valid,
    input  logic [4*NREQ-1:0]    i_req_mcand,
    input  logic [16*NREQ-1:0]   i_req_mult,
    output logic [NREQ-1:0]      o_req_ready,
    output logic [NREQ-1:0]      o_resp_valid,
    output logic [19:0]          o_resp_product,
    output logic [2:0]           o_resp_id,
    output logic                 o_resp_err,
    output logic                 o_busy,
    output logic                 o_mul_st,
    output logic [3:0]           o_mul_mcand,
    output logic [15:0]          o_mul_mult,
    input  logic [19:0]          i_mul_product,
    input  logic                 i_mul_done
);

    if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("mult_arbiter: NREQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_t;

    state_t          r_state, w_next;
    logic [2:0]      r_rr_ptr;
    logic [2:0]      r_id;
    logic            r_armed;
    logic            r_err;
    logic [19:0]     r_product;
    logic [3:0]      r_mcand;
    logic [15:0]     r_mult;

    logic [NREQ-1:0] w_rot;
    logic            w_found;
    logic [2:0]      w_win;
    logic [3:0]      w_sum;
    logic [2:0]      w_ptr_nxt;
    logic            w_capture;
    logic            w_tmo_hit;

    // Rotate so bit 0 is the requester at rr_ptr; first set bit wins.
    assign w_rot = NREQ'({i_req_valid, i_req_valid} >> r_rr_ptr);

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && ((w_rot >> k) & NREQ'(1)) != '0) begin
                w_found = 1'b1;
                w_sum   = {1'b0, r_rr_ptr} + 4'(k);
                w_win   = (w_sum >= 4'(NREQ)) ? 3'(w_sum - 4'(NREQ)) : 3'(w_sum);
            end
        end
    end

    assign w_ptr_nxt = (w_win == 3'(NREQ - 1)) ? 3'd0 : w_win + 3'd1;

    // A done seen before the armed flag is left over from the previous product.
    assign w_capture = (r_state == S_WAIT) && r_armed && i_mul_done;

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_wcnt;

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_wcnt <= '0;
        else if (r_state == S_LAUNCH)
            r_wcnt <= '0;
        else if (r_state == S_WAIT)
            r_wcnt <= r_wcnt + CW'(1);
    end

    assign w_tmo_hit = (r_state == S_WAIT) && !w_capture &&
                       (r_wcnt == CW'(TIMEOUT_CYCLES - 1));
`else
    assign w_tmo_hit = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_found) w_next = S_LAUNCH;
            S_LAUNCH: w_next = S_WAIT;
            S_WAIT:   if (w_capture || w_tmo_hit) w_next = S_RESP;
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rr_ptr  <= '0;
            r_id      <= '0;
            r_armed   <= 1'b0;
            r_err     <= 1'b0;
            r_product <= '0;
            r_mcand   <= '0;
            r_mult    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_mcand  <= 4'(i_req_mcand >> {w_win, 2'b00});
                        r_mult   <= 16'(i_req_mult >> {w_win, 4'b0000});
                        r_id     <= w_win;
                        r_rr_ptr <= w_ptr_nxt;
                        r_err    <= 1'b0;
                    end
                end
                S_LAUNCH: r_armed <= 1'b0;
                S_WAIT: begin
                    if (!i_mul_done)
                        r_armed <= 1'b1;
                    if (w_capture) begin
                        r_product <= i_mul_product;
                    end else if (w_tmo_hit) begin
                        r_product <= '0;
                        r_err     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_req_ready    = (r_state == S_IDLE && w_found && !i_rst) ? (NREQ'(1) << w_win) : '0;
    assign o_resp_valid   = (r_state == S_RESP) ? (NREQ'(1) << r_id) : '0;
    assign o_resp_product = r_product;
    assign o_resp_id      = r_id;
    assign o_resp_err     = r_err;
    assign o_busy         = (r_state != S_IDLE);
    assign o_mul_st       = (r_state == S_LAUNCH);
    assign o_mul_mcand    = r_mcand;
    assign o_mul_mult     = r_mult;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter with a behavioural multiplier model
// (configurable latency, stale-done hold, and a never-done mode).
module tb_mult_arbiter;

    localparam int MLAT = 4;
    localparam int LIM  = 200;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  a_arr [4];
    logic [15:0] b_arr [4];
    logic [15:0] req_mcand;
    logic [63:0] req_mult;
    logic [3:0]  req_ready;
    logic [3:0]  resp_valid;
    logic [19:0] resp_product;
    logic [2:0]  resp_id;
    logic        resp_err;
    logic        busy;
    logic        mul_st;
    logic [3:0]  mul_mcand;
    logic [15:0] mul_mult;
    logic [19:0] m_prod;
    logic        m_done;

    int checks = 0;
    int errors = 0;
    int m_cnt, m_hold;
    int stale_hold = 0;
    bit dead = 1'b0;

    assign req_mcand = {a_arr[3], a_arr[2], a_arr[1], a_arr[0]};
    assign req_mult  = {b_arr[3], b_arr[2], b_arr[1], b_arr[0]};

    always #5 clk = ~clk;

    mult_arbiter #(.NREQ(4), .TIMEOUT_CYCLES(64)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .i_req_mcand(req_mcand), .i_req_mult(req_mult),
        .o_req_ready(req_ready), .o_resp_valid(resp_valid),
        .o_resp_product(resp_product), .o_resp_id(resp_id), .o_resp_err(resp_err),
        .o_busy(busy), .o_mul_st(mul_st), .o_mul_mcand(mul_mcand), .o_mul_mult(mul_mult),
        .i_mul_product(m_prod), .i_mul_done(m_done)
    );

    // Multiplier model: done drops on st (unless held stale), rises MLAT cycles later.
    always @(posedge clk) begin
        if (rst) begin
            m_done <= 1'b0; m_prod <= '0; m_cnt <= 0; m_hold <= 0;
        end else if (mul_st) begin
            m_cnt  <= MLAT;
            m_hold <= stale_hold;
            if (stale_hold == 0) m_done <= 1'b0;
        end else if (m_hold != 0) begin
            m_hold <= m_hold - 1;
            if (m_hold == 1) m_done <= 1'b0;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1 && !dead) begin
                m_done <= 1'b1;
                m_prod <= 20'(mul_mcand) * 20'(mul_mult);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    // Expects requester id to win in the current IDLE cycle and follows it to RESP.
    task automatic serve(input int id, input int a, input int b, input int prod,
                         input int lat, input bit hold, input bit err);
        int cyc;
        #1;
        check("grant", 32'(req_ready), 32'(1 << id));
        @(negedge clk);
        if (!hold) req_valid[id] = 1'b0;
        check("st_launch", 32'(mul_st), 1);
        check("ready_launch", 32'(req_ready), 0);
        check("busy_launch", 32'(busy), 1);
        check("mcand", 32'(mul_mcand), 32'(a));
        check("mult", 32'(mul_mult), 32'(b));
        @(negedge clk);
        check("st_pulse", 32'(mul_st), 0);
        check("ready_wait", 32'(req_ready), 0);
        cyc = 2;
        while (resp_valid == '0 && cyc < LIM) begin
            @(negedge clk);
            cyc++;
        end
        check("resp_valid", 32'(resp_valid), 32'(1 << id));
        check("resp_product", 32'(resp_product), 32'(prod));
        check("resp_id", 32'(resp_id), 32'(id));
        check("resp_err", 32'(resp_err), 32'(err));
        check("latency", 32'(cyc), 32'(lat));
        check("ready_resp", 32'(req_ready), 0);
        @(negedge clk);
        check("resp_pulse", 32'(resp_valid), 0);
        check("busy_idle", 32'(busy), 0);
    endtask

    initial begin
        bit seen;
        rst = 1'b1;
        req_valid = '0;
        for (int i = 0; i < 4; i++) begin a_arr[i] = '0; b_arr[i] = '0; end
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(req_ready), 0);
        check("rst_resp_valid", 32'(resp_valid), 0);
        check("rst_product", 32'(resp_product), 0);
        check("rst_id", 32'(resp_id), 0);
        check("rst_err", 32'(resp_err), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_st", 32'(mul_st), 0);
        check("rst_mcand", 32'(mul_mcand), 0);
        check("rst_mult", 32'(mul_mult), 0);
        rst = 1'b0;

        // single request
        a_arr[0] = 4'd3; b_arr[0] = 16'd1000; req_valid = 4'b0001;
        serve(0, 3, 1000, 3000, 3 + MLAT, 1'b0, 1'b0);

        // corner operands on req2
        a_arr[2] = 4'd15; b_arr[2] = 16'd0; req_valid = 4'b0100;
        serve(2, 15, 0, 0, 3 + MLAT, 1'b0, 1'b0);
        b_arr[2] = 16'hFFFF; req_valid = 4'b0100;
        serve(2, 15, 65535, 983025, 3 + MLAT, 1'b0, 1'b0);

        // stale done held 2 cycles into WAIT: capture only after done drops and rises
        stale_hold = 2;
        a_arr[0] = 4'd5; b_arr[0] = 16'd100; req_valid = 4'b0001;
        serve(0, 5, 100, 500, 5 + MLAT, 1'b0, 1'b0);
        stale_hold = 0;

        // all four from reset: round-robin 0,1,2,3
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        a_arr[0] = 4'd3;  b_arr[0] = 16'd1000;
        a_arr[1] = 4'd7;  b_arr[1] = 16'd4660;
        a_arr[2] = 4'd15; b_arr[2] = 16'd65535;
        a_arr[3] = 4'd9;  b_arr[3] = 16'd40000;
        req_valid = 4'b1111;
        serve(0, 3, 1000, 3000, 3 + MLAT, 1'b0, 1'b0);
        serve(1, 7, 4660, 32620, 3 + MLAT, 1'b0, 1'b0);
        serve(2, 15, 65535, 983025, 3 + MLAT, 1'b0, 1'b0);
        serve(3, 9, 40000, 360000, 3 + MLAT, 1'b0, 1'b0);

        // req1 and req3 held: alternate 1,3,1,3
        req_valid = 4'b1010;
        serve(1, 7, 4660, 32620, 3 + MLAT, 1'b1, 1'b0);
        serve(3, 9, 40000, 360000, 3 + MLAT, 1'b1, 1'b0);
        serve(1, 7, 4660, 32620, 3 + MLAT, 1'b1, 1'b0);
        serve(3, 9, 40000, 360000, 3 + MLAT, 1'b1, 1'b0);
        req_valid = '0;

        // reset mid-WAIT aborts req1; rr_ptr would otherwise be 2
        @(negedge clk);
        req_valid = 4'b0010;
        #1;
        check("abort_grant", 32'(req_ready), 32'b0010);
        @(negedge clk);
        req_valid = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 0);
        check("abort_st", 32'(mul_st), 0);
        check("abort_resp_valid", 32'(resp_valid), 0);
        check("abort_mcand", 32'(mul_mcand), 0);
        check("abort_product", 32'(resp_product), 0);
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (resp_valid != '0 || busy) seen = 1'b1;
        end
        check("abort_no_resp", 32'(seen), 0);
        req_valid = 4'b0110;
        serve(1, 7, 4660, 32620, 3 + MLAT, 1'b0, 1'b0);
        serve(2, 15, 65535, 983025, 3 + MLAT, 1'b0, 1'b0);

`ifdef MULT_ARB_TIMEOUT_EN
        // multiplier never completes: 64 WAIT cycles then error response
        dead = 1'b1;
        req_valid = 4'b0001;
        serve(0, 3, 1000, 0, 2 + 64, 1'b0, 1'b1);
        dead = 1'b0;
        req_valid = 4'b0001;
        serve(0, 3, 1000, 3000, 3 + MLAT, 1'b0, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
